// File: rtl/fc_hwpe_sched_pkg.sv
// Shared types and defaults for the FC HWPE job sequencer.
`timescale 1ns/1ps
package fc_hwpe_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ARG   = 3'd1,
    TRIGGER  = 3'd2,
    WAIT_EVT = 3'd3,
    CLEAR    = 3'd4,
    DONE     = 3'd5
  } sched_state_e;

  localparam logic [31:0] DEF_HWPE_BASE      = 32'h1A10_C000;
  localparam logic [31:0] DEF_ARG_OFFSET     = 32'h0000_0040;
  localparam logic [31:0] DEF_TRIGGER_OFFSET = 32'h0000_0000;
  localparam logic [31:0] DEF_SOFTCLR_OFFSET = 32'h0000_0014;
  localparam int unsigned JOB_ID_W           = 8;

  function automatic logic [31:0] arg_addr(input logic [31:0] base,
                                           input logic [31:0] off,
                                           input logic [31:0] idx);
    return base + off + (idx << 2);
  endfunction

endpackage

// File: rtl/fc_hwpe_job_fifo.sv
// Descriptor queue: parametric-depth synchronous FIFO with full/empty flags.
`timescale 1ns/1ps
module fc_hwpe_job_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rptr];

  // Storage carries no reset; only pointers and occupancy do.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fc_hwpe_job_sched.sv
// Offload sequencer: queues job descriptors, programs them into the HWPE over
// the peripheral config bus, triggers, and waits for completion or timeout.
`timescale 1ns/1ps
module fc_hwpe_job_sched
  import fc_hwpe_sched_pkg::*;
#(
  parameter int unsigned N_ARGS         = 4,
  parameter int unsigned JOB_FIFO_DEPTH = 2,
  parameter logic [31:0] HWPE_BASE      = DEF_HWPE_BASE,
  parameter logic [31:0] ARG_OFFSET     = DEF_ARG_OFFSET,
  parameter logic [31:0] TRIGGER_OFFSET = DEF_TRIGGER_OFFSET,
  parameter logic [31:0] SOFTCLR_OFFSET = DEF_SOFTCLR_OFFSET,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [N_ARGS*32-1:0]  job_args_i,
  output logic                  periph_req_o,
  input  logic                  periph_gnt_i,
  output logic [31:0]           periph_add_o,
  output logic                  periph_wen_o,
  output logic [3:0]            periph_be_o,
  output logic [31:0]           periph_data_o,
  input  logic                  periph_r_valid_i,
  input  logic                  hwpe_evt_i,
  output logic                  busy_o,
  output logic                  job_done_o,
  output logic                  job_err_o,
  output logic [JOB_ID_W-1:0]   job_id_o
);

  localparam int unsigned ARGS_W    = N_ARGS * 32;
  localparam int unsigned IDX_W     = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ARGS - 1);
  localparam logic        WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WDOG_LAST = (TIMEOUT_CYCLES == 0) ? '0 : 32'(TIMEOUT_CYCLES - 1);

  sched_state_e        r_state;
  logic                r_pend;
  logic [IDX_W-1:0]    r_arg_idx;
  logic [ARGS_W-1:0]   r_args;
  logic [JOB_ID_W-1:0] r_job_id;
  logic [JOB_ID_W-1:0] r_cur_id;
  logic                r_err;
  logic [31:0]         r_wdog;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [ARGS_W-1:0]   w_fifo_data;
  logic                w_bus_state;
  logic                w_req;
  logic                w_gnt;
  logic                w_rsp;
  logic                w_timeout;
  logic [31:0]         w_addr;
  logic [31:0]         w_wdata;
  logic [31:0]         w_arg_words [N_ARGS];

  assign w_push = job_valid_i && !w_full;
  assign w_pop  = (r_state == IDLE) && !w_empty;

  fc_hwpe_job_fifo #(
    .DEPTH (JOB_FIFO_DEPTH),
    .WIDTH (ARGS_W)
  ) u_job_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (job_args_i),
    .pop_i   (w_pop),
    .data_o  (w_fifo_data),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_ARGS; i++) begin
      w_arg_words[i] = r_args[32*i +: 32];
    end
  end

  // Request is combinational from state so an async reset drops it at once.
  always_comb begin
    w_bus_state = (r_state == WR_ARG) || (r_state == TRIGGER) || (r_state == CLEAR);
    w_req       = w_bus_state && !r_pend;
    w_addr      = '0;
    w_wdata     = '0;
    if (w_req) begin
      case (r_state)
        WR_ARG: begin
          w_addr  = arg_addr(HWPE_BASE, ARG_OFFSET, 32'(r_arg_idx));
          w_wdata = w_arg_words[r_arg_idx];
        end
        TRIGGER: w_addr = HWPE_BASE + TRIGGER_OFFSET;
        CLEAR:   w_addr = HWPE_BASE + SOFTCLR_OFFSET;
        default: w_addr = '0;
      endcase
    end
  end

  assign w_gnt     = w_req && periph_gnt_i;
  assign w_rsp     = r_pend && periph_r_valid_i;
  assign w_timeout = WDOG_EN && (r_wdog == WDOG_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_pend    <= 1'b0;
      r_arg_idx <= '0;
      r_args    <= '0;
      r_job_id  <= '0;
      r_cur_id  <= '0;
      r_err     <= 1'b0;
      r_wdog    <= '0;
    end else begin
      if (w_gnt) begin
        r_pend <= 1'b1;
      end else if (w_rsp) begin
        r_pend <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_args    <= w_fifo_data;
            r_cur_id  <= r_job_id;
            r_job_id  <= r_job_id + 1'b1;
            r_arg_idx <= '0;
            r_err     <= 1'b0;
            r_state   <= WR_ARG;
          end
        end
        WR_ARG: begin
          if (w_rsp) begin
            if (r_arg_idx == LAST_IDX) begin
              r_state <= TRIGGER;
            end else begin
              r_arg_idx <= r_arg_idx + 1'b1;
            end
          end
        end
        TRIGGER: begin
          if (w_rsp) begin
            r_wdog  <= '0;
            r_state <= WAIT_EVT;
          end
        end
        WAIT_EVT: begin
          if (hwpe_evt_i) begin
            r_state <= DONE;
          end else if (w_timeout) begin
            r_state <= CLEAR;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
        end
        CLEAR: begin
          if (w_rsp) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign job_ready_o   = !w_full;
  assign periph_req_o  = w_req;
  assign periph_add_o  = w_addr;
  assign periph_data_o = w_wdata;
  assign periph_wen_o  = 1'b0;
  assign periph_be_o   = 4'hF;
  assign busy_o        = (r_state != IDLE) || !w_empty;
  assign job_done_o    = (r_state == DONE);
  assign job_err_o     = (r_state == DONE) && r_err;
  assign job_id_o      = (r_state == DONE) ? r_cur_id : '0;

endmodule

// File: tb/tb_fc_hwpe_job_sched.sv
// Directed bench for fc_hwpe_job_sched with a config-bus responder/logger.
`timescale 1ns/1ps
module tb_fc_hwpe_job_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         job_valid = 1'b0;
  logic [127:0] job_args = '0;
  logic         periph_gnt = 1'b0;
  logic         periph_r_valid = 1'b0;
  logic         hwpe_evt = 1'b0;

  logic         job_ready_o;
  logic         periph_req_o;
  logic [31:0]  periph_add_o;
  logic         periph_wen_o;
  logic [3:0]   periph_be_o;
  logic [31:0]  periph_data_o;
  logic         busy_o;
  logic         job_done_o;
  logic         job_err_o;
  logic [7:0]   job_id_o;

  int n_assert = 0;
  int n_fail   = 0;

  int          gnt_delay = 0;
  int          req_cnt   = 0;
  bit          rsp_due   = 1'b0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_add  = '0;
  logic [31:0] prev_data = '0;
  int          stab_err  = 0;
  int          proto_err = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  fc_hwpe_job_sched #(
    .N_ARGS         (4),
    .JOB_FIFO_DEPTH (2),
    .HWPE_BASE      (32'h1A10_C000),
    .ARG_OFFSET     (32'h40),
    .TRIGGER_OFFSET (32'h00),
    .SOFTCLR_OFFSET (32'h14),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .job_valid_i      (job_valid),
    .job_ready_o      (job_ready_o),
    .job_args_i       (job_args),
    .periph_req_o     (periph_req_o),
    .periph_gnt_i     (periph_gnt),
    .periph_add_o     (periph_add_o),
    .periph_wen_o     (periph_wen_o),
    .periph_be_o      (periph_be_o),
    .periph_data_o    (periph_data_o),
    .periph_r_valid_i (periph_r_valid),
    .hwpe_evt_i       (hwpe_evt),
    .busy_o           (busy_o),
    .job_done_o       (job_done_o),
    .job_err_o        (job_err_o),
    .job_id_o         (job_id_o)
  );

  always #5 clk = ~clk;

  // Responder: grant after gnt_delay waiting cycles, respond one cycle after grant.
  always @(negedge clk) begin
    periph_r_valid = rsp_due;
    rsp_due = 1'b0;
    if (periph_req_o) begin
      if (periph_wen_o !== 1'b0 || periph_be_o !== 4'hF) proto_err++;
      if (prev_wait && (periph_add_o !== prev_add || periph_data_o !== prev_data)) stab_err++;
      periph_gnt = (req_cnt >= gnt_delay);
      req_cnt++;
    end else begin
      if (prev_wait && rst_n) stab_err++;
      periph_gnt = 1'b0;
      req_cnt = 0;
    end
    prev_wait = periph_req_o && !periph_gnt;
    prev_add  = periph_add_o;
    prev_data = periph_data_o;
    if (periph_req_o && periph_gnt) begin
      log_addr.push_back(periph_add_o);
      log_data.push_back(periph_data_o);
      rsp_due = 1'b1;
      req_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_job(input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3);
    job_args  = {a3, a2, a1, a0};
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input string tag);
    for (int i = 0; i < 200 && log_addr.size() < n; i++) step();
    if (log_addr.size() < n) chk(tag, 32'(log_addr.size()), 32'(n));
  endtask

  task automatic pulse_evt();
    hwpe_evt = 1'b1;
    step();
    hwpe_evt = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100 && !job_done_o; i++) step();
    chk(tag, 32'(job_done_o), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    job_valid = 1'b0;
    hwpe_evt = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic chk_job_log(input string tag, input logic [31:0] d0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), log_addr[i], 32'h1A10_C040 + 32'(4*i));
      chk($sformatf("%s_data%0d", tag, i), log_data[i], d0 + 32'(i));
    end
    chk({tag, "_trig_addr"}, log_addr[4], 32'h1A10_C000);
    chk({tag, "_trig_data"}, log_data[4], 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int cnt;
    int dones;

    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(job_ready_o), 32'd1);
    chk("rst_be", 32'(periph_be_o), 32'hF);
    chk("rst_req", 32'(periph_req_o), 32'd0);
    chk("rst_add", periph_add_o, 32'd0);
    chk("rst_data", periph_data_o, 32'd0);
    chk("rst_wen", 32'(periph_wen_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(job_done_o), 32'd0);
    chk("rst_err", 32'(job_err_o), 32'd0);
    chk("rst_id", 32'(job_id_o), 32'd0);
    rst_n = 1'b1;
    step();

    // Single job, gnt always granted.
    push_job(32'd1, 32'd2, 32'd3, 32'd4);
    chk("t1_busy_queued", 32'(busy_o), 32'd1);
    wait_log(5, "t1_log_timeout");
    repeat (10) step();
    pulse_evt();
    wait_done("t1_done");
    chk("t1_id", 32'(job_id_o), 32'd0);
    chk("t1_err", 32'(job_err_o), 32'd0);
    chk("t1_busy_in_done", 32'(busy_o), 32'd1);
    step();
    chk("t1_done_one_cycle", 32'(job_done_o), 32'd0);
    chk("t1_busy_after", 32'(busy_o), 32'd0);
    chk("t1_nwrites", 32'(log_addr.size()), 32'd5);
    chk_job_log("t1", 32'd1);

    // Backpressure: three waiting cycles per transaction.
    log_addr.delete();
    log_data.delete();
    gnt_delay = 3;
    push_job(32'd5, 32'd6, 32'd7, 32'd8);
    wait_log(5, "t2_log_timeout");
    repeat (3) step();
    pulse_evt();
    wait_done("t2_done");
    chk("t2_id", 32'(job_id_o), 32'd1);
    chk("t2_err", 32'(job_err_o), 32'd0);
    step();
    chk("t2_nwrites", 32'(log_addr.size()), 32'd5);
    chk_job_log("t2", 32'd5);
    chk("t2_stable", 32'(stab_err), 32'd0);
    chk("t2_wen_be", 32'(proto_err), 32'd0);
    gnt_delay = 0;

    // Queue full while the first job waits for its event.
    do_reset();
    push_job(32'h10, 32'h11, 32'h12, 32'h13);
    wait_log(5, "t3_log_a");
    job_args  = {32'h23, 32'h22, 32'h21, 32'h20};
    job_valid = 1'b1;
    step();
    chk("t3_ready_one_queued", 32'(job_ready_o), 32'd1);
    job_args  = {32'h33, 32'h32, 32'h31, 32'h30};
    step();
    job_valid = 1'b0;
    chk("t3_ready_full", 32'(job_ready_o), 32'd0);
    pulse_evt();
    wait_done("t3_done_a");
    chk("t3_id_a", 32'(job_id_o), 32'd0);
    job_args  = {32'h43, 32'h42, 32'h41, 32'h40};
    job_valid = 1'b1;
    for (int i = 0; i < 20 && !job_ready_o; i++) step();
    chk("t3_ready_back", 32'(job_ready_o), 32'd1);
    step();
    job_valid = 1'b0;
    wait_log(10, "t3_log_b");
    repeat (3) step();
    pulse_evt();
    wait_done("t3_done_b");
    chk("t3_id_b", 32'(job_id_o), 32'd1);
    wait_log(15, "t3_log_c");
    repeat (3) step();
    pulse_evt();
    wait_done("t3_done_c");
    chk("t3_id_c", 32'(job_id_o), 32'd2);
    wait_log(20, "t3_log_d");
    repeat (3) step();
    pulse_evt();
    wait_done("t3_done_d");
    chk("t3_id_d", 32'(job_id_o), 32'd3);
    chk("t3_order_b", log_data[5], 32'h20);
    chk("t3_order_c", log_data[10], 32'h30);
    chk("t3_order_d", log_data[15], 32'h40);
    step();
    chk("t3_busy_end", 32'(busy_o), 32'd0);
    chk("t3_ready_end", 32'(job_ready_o), 32'd1);

    // Watchdog timeout with no event.
    log_addr.delete();
    log_data.delete();
    push_job(32'h50, 32'h51, 32'h52, 32'h53);
    wait_log(5, "t4_log_timeout");
    cnt = 0;
    while (log_addr.size() < 6 && cnt < 60) begin
      step();
      cnt++;
    end
    chk("t4_softclr_cycle", 32'(cnt), 32'd18);
    chk("t4_softclr_addr", log_addr[5], 32'h1A10_C014);
    chk("t4_softclr_data", log_data[5], 32'h0);
    wait_done("t4_done");
    chk("t4_err", 32'(job_err_o), 32'd1);
    chk("t4_id", 32'(job_id_o), 32'd4);
    step();
    pulse_evt();
    dones = 0;
    repeat (20) begin
      step();
      if (job_done_o) dones++;
    end
    chk("t4_late_evt_ignored", 32'(dones), 32'd0);
    chk("t4_nwrites", 32'(log_addr.size()), 32'd6);
    chk("t4_busy_end", 32'(busy_o), 32'd0);

    // Event on the very cycle the watchdog expires.
    log_addr.delete();
    log_data.delete();
    push_job(32'h60, 32'h61, 32'h62, 32'h63);
    wait_log(5, "t5_log_timeout");
    repeat (17) step();
    hwpe_evt = 1'b1;
    step();
    hwpe_evt = 1'b0;
    chk("t5_done", 32'(job_done_o), 32'd1);
    chk("t5_err", 32'(job_err_o), 32'd0);
    chk("t5_id", 32'(job_id_o), 32'd5);
    repeat (5) step();
    chk("t5_no_softclr", 32'(log_addr.size()), 32'd5);

    // ID counter wrap over 257 jobs.
    do_reset();
    for (int j = 0; j < 257; j++) begin
      log_addr.delete();
      log_data.delete();
      push_job(32'(j), 32'd0, 32'd0, 32'd0);
      wait_log(5, "t6_log_timeout");
      repeat (3) step();
      pulse_evt();
      wait_done("t6_done");
      if (j == 255) chk("t6_id_255", 32'(job_id_o), 32'd255);
      if (j == 256) chk("t6_id_wrap", 32'(job_id_o), 32'd0);
    end
    step();

    // Reset asserted while an argument write is outstanding.
    gnt_delay = 3;
    push_job(32'h70, 32'h71, 32'h72, 32'h73);
    for (int i = 0; i < 20 && !periph_req_o; i++) step();
    chk("t7_req_before", 32'(periph_req_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_req_drop", 32'(periph_req_o), 32'd0);
    chk("t7_add", periph_add_o, 32'd0);
    chk("t7_data", periph_data_o, 32'd0);
    chk("t7_ready", 32'(job_ready_o), 32'd1);
    chk("t7_busy", 32'(busy_o), 32'd0);
    chk("t7_done", 32'(job_done_o), 32'd0);
    chk("t7_err", 32'(job_err_o), 32'd0);
    chk("t7_id", 32'(job_id_o), 32'd0);
    chk("t7_be", 32'(periph_be_o), 32'hF);
    step();
    step();
    rst_n = 1'b1;
    gnt_delay = 0;
    repeat (5) step();
    chk("t7_no_softclr", 32'(periph_req_o), 32'd0);
    chk("t7_idle_after", 32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
